// File: rtl/fifo_drain_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_drain_arbiter_if                                        |
// | Description : FIFO-side and stream-side signal bundle for the FIFO drain   |
// |               arbiter. master = arbiter view, slave = environment view.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface fifo_drain_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 6
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH*CNT_WIDTH-1:0]  ch_count;
  logic [NUM_CH-1:0]            ch_rd_en;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [CH_W-1:0]              m_chan;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready;

  modport master (
    input  ch_data, ch_valid, ch_count, m_ready,
    output ch_rd_en, m_data, m_chan, m_valid, m_last
  );

  modport slave (
    output ch_data, ch_valid, ch_count, m_ready,
    input  ch_rd_en, m_data, m_chan, m_valid, m_last
  );
endinterface
`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_drain_arbiter                                           |
// | Description : Round-robin drain of NUM_CH first-word-fall-through FIFOs    |
// |               into one tagged valid/ready stream, bursts of up to BURST.   |
// |               Optional macro ARB_STATS_EN adds grant/beat counters.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fifo_drain_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 6,
  parameter int BURST      = 8,
  parameter int MIN_FILL   = 1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  input  wire logic  enable,
  output logic       busy,
`ifdef ARB_STATS_EN
  input  wire logic  stat_clr,
  output logic [15:0] stat_bursts,
  output logic [31:0] stat_beats,
`endif
  fifo_drain_arbiter_if.master bus
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] BURST_C    = CNT_WIDTH'(BURST);
  localparam logic [CNT_WIDTH-1:0] MIN_FILL_C = CNT_WIDTH'(MIN_FILL);
  localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [CH_W-1:0]      grant, grant_nxt;
  logic [CH_W-1:0]      last_grant, last_grant_nxt;
  logic [CH_W-1:0]      pick, idx;
  logic [CNT_WIDTH-1:0] beats, beats_nxt;
  logic                 found;
  logic                 handshake;

  logic [DATA_WIDTH-1:0] data_arr  [NUM_CH];
  logic [CNT_WIDTH-1:0]  count_arr [NUM_CH];
  logic [NUM_CH-1:0]     req;

  logic [DATA_WIDTH-1:0] m_data;
  logic [CH_W-1:0]       m_chan;
  logic                  m_valid;
  logic                  m_last;
  logic [NUM_CH-1:0]     ch_rd_en;

  // Unpack the flat per-channel buses and form the fill-level requests.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign data_arr[i]  = bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign count_arr[i] = bus.ch_count[i*CNT_WIDTH +: CNT_WIDTH];
      assign req[i]       = (count_arr[i] >= MIN_FILL_C);
    end
  endgenerate

  // Circular search for the first requester after the previous grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // FSM state and burst bookkeeping; reset abandons any burst at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      beats      <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beats      <= beats_nxt;
    end
  end

  // Next state, burst length latch and the combinational FIFO-to-stream path.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beats_nxt      = beats;
    busy           = 1'b0;
    m_valid        = 1'b0;
    m_data         = '0;
    m_chan         = '0;
    m_last         = 1'b0;
    handshake      = 1'b0;
    ch_rd_en       = '0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          grant_nxt      = pick;
          last_grant_nxt = pick;
          // Burst length is frozen here; later FIFO writes do not extend it.
          beats_nxt      = (count_arr[pick] > BURST_C) ? BURST_C : count_arr[pick];
          state_nxt      = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        m_valid   = bus.ch_valid[grant];
        m_data    = data_arr[grant];
        m_chan    = grant;
        m_last    = m_valid && (beats == ONE_C);
        handshake = m_valid && bus.m_ready;
        if (handshake) begin
          ch_rd_en[grant] = 1'b1;
          beats_nxt       = beats - ONE_C;
          if (beats == ONE_C) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m_data   = m_data;
  assign bus.m_chan   = m_chan;
  assign bus.m_valid  = m_valid;
  assign bus.m_last   = m_last;
  assign bus.ch_rd_en = ch_rd_en;

`ifdef ARB_STATS_EN
  logic grant_now;
  assign grant_now = (state == IDLE) && enable && found;

  // Saturating grant/beat counters; a clear request wins over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
    end else if (stat_clr) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
    end else begin
      if (grant_now && (stat_bursts != 16'hFFFF)) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
      if (handshake && (stat_beats != 32'hFFFF_FFFF)) begin
        stat_beats <= stat_beats + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_drain_arbiter                                        |
// | Description : Scoreboard bench for fifo_drain_arbiter with queue-based     |
// |               FIFO models and a transaction-level round-robin model.       |
// |               Stats checks are compiled in when ARB_STATS_EN is defined.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_drain_arbiter;
  localparam int NUM_CH   = 4;
  localparam int DW       = 16;
  localparam int CW       = 6;
  localparam int BURST    = 8;
  localparam int MIN_FILL = 1;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_bursts;
  logic [31:0] stat_beats;
`endif

  fifo_drain_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST(BURST), .MIN_FILL(MIN_FILL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .busy(busy),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr),
    .stat_bursts(stat_bursts),
    .stat_beats(stat_beats),
`endif
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic [DW-1:0]     fq [NUM_CH][$];
  logic [NUM_CH-1:0] hide = '0;
  logic [NUM_CH-1:0] pop_mask = '0;
  exp_t              exp_q [$];

  int m_rem = 0;
  int m_g = 0;
  int m_last_g = NUM_CH - 1;
  int exp_bursts = 0;
  int exp_beats = 0;
  int hs_total = 0;
  int last_hs_chan = -1;
  int n_checks = 0;
  int n_pass = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [1:0]    prev_chan = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
  endtask

  task automatic drive_ch();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_data[i*DW +: DW]  = (fq[i].size() > 0) ? fq[i][0] : '0;
      bus.ch_valid[i]          = (fq[i].size() > 0) && !hide[i];
      bus.ch_count[i*CW +: CW] = CW'((fq[i].size() > 63) ? 63 : fq[i].size());
    end
  endtask

  function automatic int fifo_total();
    int t = 0;
    for (int i = 0; i < NUM_CH; i++) t += fq[i].size();
    return t;
  endfunction

  task automatic push(input int ch, input int n);
    for (int j = 0; j < n; j++) fq[ch].push_back(DW'($urandom));
  endtask

  // Reference model: one transaction-level step per clock edge.
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0;
      m_last_g = NUM_CH - 1;
      exp_q.delete();
      exp_bursts = 0;
      exp_beats = 0;
    end else begin
      if (m_rem == 0) begin
        if (enable) begin
          for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_last_g + k) % NUM_CH;
            if (fq[c].size() >= MIN_FILL) begin
              int n;
              n = (fq[c].size() > BURST) ? BURST : fq[c].size();
              for (int j = 0; j < n; j++) begin
                exp_t e;
                e.chan = 2'(c);
                e.data = fq[c][j];
                e.last = (j == n - 1);
                exp_q.push_back(e);
              end
              m_g = c;
              m_last_g = c;
              m_rem = n;
              exp_bursts++;
              break;
            end
          end
        end
      end else if (bus.ch_valid[m_g] && bus.m_ready) begin
        m_rem--;
        exp_beats++;
      end
`ifdef ARB_STATS_EN
      if (stat_clr) begin
        exp_bursts = 0;
        exp_beats = 0;
      end
`endif
    end
  end

  // FIFO models: apply the pops the DUT strobed, then refresh the FIFO outputs.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++)
      if (pop_mask[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    drive_ch();
  end

  // Monitor: check outputs mid-cycle and retire scoreboard entries on handshakes.
  always @(negedge clk) begin
    pop_mask = bus.ch_rd_en;
    if (reset) begin
      chk("rst_outputs", {busy, bus.m_valid, bus.m_last, bus.m_data, bus.m_chan}, '0);
      chk("rst_rd_en", bus.ch_rd_en, '0);
      prev_stall = 1'b0;
    end else begin
      chk("busy", busy, m_rem > 0);
      chk("m_valid", bus.m_valid, (m_rem > 0) && bus.ch_valid[m_g]);
      if (prev_stall && bus.m_valid) begin
        chk("stall_hold", {bus.m_chan, bus.m_data}, {prev_chan, prev_data});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e.data);
          chk("m_chan", bus.m_chan, e.chan);
          chk("m_last", bus.m_last, e.last);
          chk("rd_en_hs", bus.ch_rd_en, 4'(1) << e.chan);
        end
        hs_total++;
        last_hs_chan = int'(bus.m_chan);
      end else begin
        chk("rd_en_idle", bus.ch_rd_en, '0);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_chan  = bus.m_chan;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int maxc, input bit need_empty, input string nm);
    int c = 0;
    while (!(m_rem == 0 && exp_q.size() == 0 && (!need_empty || fifo_total() == 0)) && c < maxc) begin
      step();
      c++;
    end
    chk({nm, "_timeout"}, c < maxc, 1'b1);
  endtask

  task automatic wait_hs(input int target, input int maxc, input string nm);
    int c = 0;
    while (hs_total < target && c < maxc) begin
      step();
      c++;
    end
    chk({nm, "_timeout"}, c < maxc, 1'b1);
  endtask

  initial begin
    int hs0;
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset with random inputs, then idle with enable low.
    for (int i = 0; i < NUM_CH; i++) push(i, int'($urandom_range(0, 5)));
    bus.m_ready = 1'($urandom);
    enable = 1'($urandom);
    drive_ch();
    repeat (3) step();
    enable = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) push(i, 2);
    drive_ch();
    repeat (5) step();
    for (int i = 0; i < NUM_CH; i++) fq[i].delete();
    drive_ch();
    step();

    // Single short burst from channel 2.
    hs0 = hs_total;
    push(2, 3);
    bus.m_ready = 1'b1;
    enable = 1'b1;
    drive_ch();
    wait_idle(100, 1'b1, "t2");
    chk("t2_beats", hs_total - hs0, 3);

    // Round robin across three deep channels.
    enable = 1'b0;
    step();
    hs0 = hs_total;
    push(0, 20); push(1, 20); push(3, 20);
    drive_ch();
    enable = 1'b1;
    wait_idle(400, 1'b1, "t3");
    chk("t3_beats", hs_total - hs0, 60);

    // Backpressure pattern 1,0,0,1.
    hs0 = hs_total;
    push(1, 8);
    drive_ch();
    for (int c = 0; c < 40; c++) begin
      bus.m_ready = pat[c % 4];
      step();
    end
    bus.m_ready = 1'b1;
    wait_idle(100, 1'b1, "t4");
    chk("t4_beats", hs_total - hs0, 8);

    // Enable drop after the second beat of an 8-word burst.
    enable = 1'b0;
    step();
    push(2, 10); push(0, 10);
    drive_ch();
    hs0 = hs_total;
    enable = 1'b1;
    wait_hs(hs0 + 2, 100, "t5_start");
    enable = 1'b0;
    wait_idle(100, 1'b0, "t5");
    chk("t5_beats", hs_total - hs0, 8);
    repeat (6) step();
    chk("t5_no_grant", hs_total - hs0, 8);
    enable = 1'b1;
    wait_idle(200, 1'b1, "t5_drain");

    // Reset in the middle of a burst; next grant must restart from channel 0.
    hs0 = hs_total;
    push(1, 10);
    drive_ch();
    wait_hs(hs0 + 4, 100, "t6_start");
    reset = 1'b1;
    step();
    step();
    push(0, 3);
    drive_ch();
    hs0 = hs_total;
    reset = 1'b0;
    wait_hs(hs0 + 1, 100, "t6_first");
    chk("t6_first_chan", last_hs_chan, 0);
    wait_idle(200, 1'b1, "t6_drain");

    // Randomized traffic, stalls, enable gaps and hidden FIFO heads.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int ch;
        ch = int'($urandom_range(0, NUM_CH - 1));
        if (fq[ch].size() < 40) push(ch, int'($urandom_range(1, 12)));
      end
      bus.m_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      hide = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
      drive_ch();
      step();
    end
    hide = '0;
    bus.m_ready = 1'b1;
    enable = 1'b1;
    drive_ch();
    wait_idle(1000, 1'b1, "rand_drain");

`ifdef ARB_STATS_EN
    chk("stat_bursts", stat_bursts, 16'(exp_bursts));
    chk("stat_beats", stat_beats, 32'(exp_beats));
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step();
    chk("stat_bursts_clr", stat_bursts, 16'd0);
    chk("stat_beats_clr", stat_beats, 32'd0);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
